// File: rtl/fabric_memreq_tagger.sv
// fabric_memreq_tagger
// Merges several untagged memory request sources onto one tagged request
// channel. Each outgoing request carries the index of its source port as a
// tag, so completions returning from external memory can be credited back to
// the right port. A per-port outstanding counter limits how many requests a
// port may have in flight, and a sticky error latch records the first
// completion that carries a bad tag or has no matching request.

module fabric_memreq_tagger #(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 in_valid,
    output logic [NUM_PORTS-1:0]                 in_ready,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0]      out_data,
    input  logic                                 done_valid,
    output logic                                 done_ready,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0]      done_data,
    output logic                                 error_valid,
    output logic [15:0]                          error_code
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int OUT_W = DATA_WIDTH + TAG_WIDTH;
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    // Runtime error codes shared with the rest of the memory fabric.
    localparam logic [15:0] RT_MEMORY_TAG_OOB        = 16'h0A01;
    localparam logic [15:0] RT_MEMORY_DONE_UNDERFLOW = 16'h0A02;

    // Reject parameter combinations that cannot work.
    if (NUM_PORTS < 2) begin : g_chk_ports
        $fatal(1, "fabric_memreq_tagger: NUM_PORTS must be at least 2");
    end
    if ((1 << TAG_WIDTH) < NUM_PORTS) begin : g_chk_tag
        $fatal(1, "fabric_memreq_tagger: TAG_WIDTH too narrow for NUM_PORTS");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_chk_max
        $fatal(1, "fabric_memreq_tagger: MAX_OUTSTANDING must be in 1..255");
    end
    if (DATA_WIDTH < 1) begin : g_chk_data
        $fatal(1, "fabric_memreq_tagger: DATA_WIDTH must be at least 1");
    end

    logic [PTR_W-1:0]           rr_ptr;
    logic [NUM_PORTS-1:0][7:0]  cnt;
    logic                       load_en;
    logic [NUM_PORTS-1:0]       eligible;
    logic                       grant_valid;
    logic [PTR_W-1:0]           grant_idx;
    logic                       grant_fire;
    logic [TAG_WIDTH-1:0]       done_tag;
    logic                       tag_oob;
    logic [NUM_PORTS-1:0]       done_hit;
    logic                       underflow;
    logic                       unused_done_payload;

    // Completions are always accepted; the payload half is not needed here.
    assign done_ready          = 1'b1;
    assign done_tag            = done_data[OUT_W-1 -: TAG_WIDTH];
    assign unused_done_payload = ^done_data[DATA_WIDTH-1:0];

    // The output register can take a new entry when empty or draining.
    assign load_en    = !out_valid || out_ready;
    assign grant_fire = load_en && grant_valid;

    // A port competes only while it has a request and spare credit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = in_valid[i] && (cnt[i] < MAX_CNT);
        end
    end

    // Round-robin search from rr_ptr upward; scanning offsets from the far
    // end backwards lets the nearest eligible port overwrite the others.
    always_comb begin
        logic [PTR_W:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_PORTS)) begin
                idx = idx - (PTR_W+1)'(NUM_PORTS);
            end
            if (eligible[idx[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
            end
        end
    end

    // One-hot ready to the granted source, held low throughout reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_ready[i] = rst_n && grant_fire && (grant_idx == PTR_W'(i));
        end
    end

    // Decode which port a completion belongs to and whether it is bogus.
    always_comb begin
        tag_oob   = done_valid && (int'(done_tag) >= NUM_PORTS);
        done_hit  = '0;
        underflow = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            done_hit[i] = done_valid && !tag_oob && (done_tag == TAG_WIDTH'(i));
            if (done_hit[i] && (cnt[i] == 8'd0)) begin
                underflow = 1'b1;
            end
        end
    end

    // Single-entry output register and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= {TAG_WIDTH'(grant_idx), in_data[grant_idx]};
                rr_ptr    <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Outstanding counters: a grant and a completion on the same port in the
    // same cycle cancel, and a completion with no credit to return is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_fire && (grant_idx == PTR_W'(i)) && !done_hit[i]) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end else if (done_hit[i] && !(grant_fire && (grant_idx == PTR_W'(i)))
                             && (cnt[i] != 8'd0)) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end
            end
        end
    end

    // Sticky error latch keeps the first error only; bad tags win over underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_valid <= 1'b0;
            error_code  <= '0;
        end else if (!error_valid && (tag_oob || underflow)) begin
            error_valid <= 1'b1;
            error_code  <= tag_oob ? RT_MEMORY_TAG_OOB : RT_MEMORY_DONE_UNDERFLOW;
        end
    end

endmodule

// File: tb/tb_fabric_memreq_tagger.sv
// Testbench for fabric_memreq_tagger: two ports, 2-bit tags so an
// out-of-range tag exists, and a credit limit of two per port.

module tb_fabric_memreq_tagger;

    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int TW    = 2;
    localparam int MO    = 2;
    localparam int OUT_W = DW + TW;

    localparam logic [15:0] CODE_OOB       = 16'h0A01;
    localparam logic [15:0] CODE_UNDERFLOW = 16'h0A02;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NP-1:0]              in_valid;
    logic [NP-1:0]              in_ready;
    logic [NP-1:0][DW-1:0]      in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_W-1:0]           out_data;
    logic                       done_valid;
    logic                       done_ready;
    logic [OUT_W-1:0]           done_data;
    logic                       error_valid;
    logic [15:0]                error_code;

    int                         checks   = 0;
    int                         failures = 0;
    logic [OUT_W-1:0]           sb_q[$];
    logic [OUT_W-1:0]           sb_exp;
    bit                         sb_en    = 1'b0;
    logic [NP-1:0]              hs;
    logic                       obs_v;
    logic [OUT_W-1:0]           obs_d;
    logic [TW-1:0]              exp_tag;
    int                         seen;
    int                         grants;
    int                         issued;

    fabric_memreq_tagger #(
        .NUM_PORTS(NP),
        .DATA_WIDTH(DW),
        .TAG_WIDTH(TW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .done_valid(done_valid),
        .done_ready(done_ready),
        .done_data(done_data),
        .error_valid(error_valid),
        .error_code(error_code)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Scoreboard: expect {port, payload} one entry per accepted input, and
    // compare against each request that leaves the output register.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sb_unexpected got=%h expected=none", out_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (out_data !== sb_exp) begin
                        failures++;
                        $display("[TB] FAIL sb_out_data got=%h expected=%h", out_data, sb_exp);
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    sb_q.push_back({TW'(i), in_data[i]});
                end
            end
        end
    end

    // Step to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        done_valid = 1'b0;
        done_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sb_q.delete();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid  = 2'b11;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) cyc();
        checks++;
        if (in_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b expected=00", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_output got=%b/%h expected=0/0", out_valid, out_data);
        end
        checks++;
        if (error_valid !== 1'b0 || error_code !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_error got=%b/%h expected=0/0000", error_valid, error_code);
        end
        checks++;
        if (done_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_done_ready got=%b expected=1", done_ready);
        end
        in_valid = '0;
        rst_n    = 1'b1;
    endtask

    task automatic test_fairness();
        do_reset();
        sb_en     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        in_data[0] = 32'hA000_0000;
        in_data[1] = 32'hB000_0000;
        exp_tag   = '0;
        seen      = 0;
        for (int c = 0; c < 30 && seen < 8; c++) begin
            @(negedge clk);
            hs    = in_valid & in_ready;
            obs_v = out_valid;
            obs_d = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data[OUT_W-1 -: TW] !== exp_tag) begin
                    failures++;
                    $display("[TB] FAIL fair_tag n=%0d got=%0d expected=%0d",
                             seen, out_data[OUT_W-1 -: TW], exp_tag);
                end
                exp_tag = (exp_tag == 2'd0) ? 2'd1 : 2'd0;
                seen++;
            end
            cyc();
            done_valid = obs_v;
            done_data  = obs_d;
            for (int i = 0; i < NP; i++) begin
                if (hs[i]) in_data[i] = in_data[i] + 32'd1;
            end
        end
        checks++;
        if (seen != 8) begin
            failures++;
            $display("[TB] FAIL fair_count got=%0d expected=8", seen);
        end
        done_valid = 1'b0;
        in_valid   = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        sb_en      = 1'b1;
        out_ready  = 1'b0;
        in_valid   = 2'b01;
        in_data[0] = 32'h10;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bp_first_accept got=%b expected=01", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== {2'b00, 32'h10} || in_ready !== 2'b00) begin
                failures++;
                $display("[TB] FAIL bp_hold c=%0d got=%b/%h/%b expected=1/%h/00",
                         c, out_valid, out_data, in_ready, {2'b00, 32'h10});
            end
        end
        cyc();
        out_ready = 1'b1;
        in_valid  = '0;
        issued    = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid && out_ready) issued++;
        end
        checks++;
        if (issued != 1) begin
            failures++;
            $display("[TB] FAIL bp_issue_count got=%0d expected=1", issued);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        sb_en      = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 2'b10;
        in_data[1] = 32'hC0;
        grants     = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) grants++;
        end
        checks++;
        if (grants != 2) begin
            failures++;
            $display("[TB] FAIL credit_grants got=%0d expected=2", grants);
        end
        checks++;
        if (in_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL credit_blocked got=%b expected=00", in_ready);
        end
        cyc();
        done_valid = 1'b1;
        done_data  = {2'd1, 32'h0};
        grants     = 0;
        @(negedge clk);
        if (in_valid[1] && in_ready[1]) grants++;
        cyc();
        done_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) grants++;
        end
        checks++;
        if (grants != 1) begin
            failures++;
            $display("[TB] FAIL credit_regrant got=%0d expected=1", grants);
        end
        cyc();
        in_valid   = 2'b11;
        in_data[0] = 32'hD0;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL credit_skip got=%b expected=01", in_ready);
        end
        cyc();
        in_valid = '0;
    endtask

    task automatic test_back_to_back_done();
        do_reset();
        sb_en      = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 2'b01;
        in_data[0] = 32'h55;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL simul_first got=%b expected=01", in_ready);
        end
        cyc();
        done_valid = 1'b1;
        done_data  = {2'd0, 32'h0};
        in_data[0] = 32'h56;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL simul_grant got=%b expected=01", in_ready);
        end
        cyc();
        done_valid = 1'b0;
        in_data[0] = 32'h57;
        grants     = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) grants++;
        end
        checks++;
        if (grants != 1) begin
            failures++;
            $display("[TB] FAIL simul_cnt_left got=%0d expected=1", grants);
        end
        checks++;
        if (error_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_no_error got=%b expected=0", error_valid);
        end
        in_valid = '0;
    endtask

    task automatic test_errors();
        do_reset();
        sb_en      = 1'b1;
        done_valid = 1'b1;
        done_data  = {2'd3, 32'h1234};
        @(negedge clk);
        checks++;
        if (error_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_before got=%b expected=0", error_valid);
        end
        cyc();
        done_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (error_valid !== 1'b1 || error_code !== CODE_OOB) begin
            failures++;
            $display("[TB] FAIL err_oob got=%b/%h expected=1/%h", error_valid, error_code, CODE_OOB);
        end
        cyc();
        done_valid = 1'b1;
        done_data  = {2'd0, 32'h0};
        cyc();
        done_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (error_valid !== 1'b1 || error_code !== CODE_OOB) begin
            failures++;
            $display("[TB] FAIL err_sticky got=%b/%h expected=1/%h", error_valid, error_code, CODE_OOB);
        end

        do_reset();
        out_ready  = 1'b1;
        in_valid   = 2'b01;
        in_data[0] = 32'h77;
        done_valid = 1'b1;
        done_data  = {2'd0, 32'h0};
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL uf_grant got=%b expected=01", in_ready);
        end
        cyc();
        done_valid = 1'b0;
        in_data[0] = 32'h78;
        @(negedge clk);
        checks++;
        if (error_valid !== 1'b1 || error_code !== CODE_UNDERFLOW) begin
            failures++;
            $display("[TB] FAIL uf_code got=%b/%h expected=1/%h", error_valid, error_code, CODE_UNDERFLOW);
        end
        grants = 0;
        if (in_valid[0] && in_ready[0]) grants++;
        repeat (4) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) grants++;
        end
        checks++;
        if (grants != 2) begin
            failures++;
            $display("[TB] FAIL uf_cnt_left got=%0d expected=2", grants);
        end
        in_valid = '0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        sb_en      = 1'b1;
        out_ready  = 1'b0;
        in_valid   = 2'b01;
        in_data[0] = 32'h99;
        cyc();
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pending got=%b expected=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        in_valid = 2'b11;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL mid_async_clear got=%b/%h expected=0/0", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_in_ready got=%b expected=00", in_ready);
        end
        cyc();
        rst_n     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_no_replay got=%b expected=0", out_valid);
        end
        cyc();
        in_valid   = 2'b11;
        in_data[0] = 32'hE0;
        in_data[1] = 32'hE1;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_first_grant got=%b expected=01", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== {2'd0, 32'hE0}) begin
            failures++;
            $display("[TB] FAIL mid_first_out got=%b/%h expected=1/%h", out_valid, out_data, {2'd0, 32'hE0});
        end
        cyc();
        in_valid = '0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_credit_limit();
        test_back_to_back_done();
        test_errors();
        test_reset_midstream();
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fabric_memreq_tagger.md
FABRIC_MEMREQ_TAGGER -- requirements
Module: fabric_memreq_tagger

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_PORTS, 2, number of untagged request sources
- DATA_WIDTH, 32, request payload width
- TAG_WIDTH, 1, tag width; SHALL satisfy 2**TAG_WIDTH >= NUM_PORTS
- MAX_OUTSTANDING, 4, per-port in-flight request limit, range 1..255

REQ-002 Ports SHALL be, one per line:
- clk  input  1  clock; one clock domain only
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  NUM_PORTS  per-source request valid
- in_ready  output  NUM_PORTS  per-source request ready
- in_data  input  NUM_PORTS x DATA_WIDTH  per-source request payload (address)
- out_valid  output  1  tagged request valid, to extmemory ld_addr
- out_ready  input  1  tagged request ready
- out_data  output  DATA_WIDTH+TAG_WIDTH  {tag, payload}; tag in the upper TAG_WIDTH bits
- done_valid  input  1  completion from extmemory ld_done
- done_ready  output  1  completion ready, tied to 1
- done_data  input  DATA_WIDTH+TAG_WIDTH  completion; tag in the upper TAG_WIDTH bits
- error_valid  output  1  sticky error flag
- error_code  output  16  error code

REQ-003 Elaboration SHALL $fatal under any of these conditions:
- NUM_PORTS < 2
- 2**TAG_WIDTH < NUM_PORTS
- MAX_OUTSTANDING outside 1..255
- DATA_WIDTH < 1

Function
REQ-004 The output stage SHALL be a single registered entry; out_valid and out_data SHALL both be flops.
REQ-005 The block SHALL take a new entry (load_en) when out_valid==0 or (out_valid && out_ready), giving full throughput of one request per cycle.
REQ-006 Port i SHALL be eligible when in_valid[i] && cnt[i] < MAX_OUTSTANDING.
REQ-007 Arbitration SHALL be round-robin: search eligible ports starting at rr_ptr, ascending, wrapping from NUM_PORTS-1 to 0; the first hit is the grant.
REQ-008 in_ready[i] SHALL equal load_en && grant==i, and SHALL be combinational from current state and in_valid; at most one in_ready bit SHALL be high per cycle.
REQ-009 On a grant, the next state SHALL be:
- out_valid <= 1
- out_data <= {TAG_WIDTH'(i), in_data[i]}
- rr_ptr <= (i==NUM_PORTS-1) ? 0 : i+1
REQ-010 If load_en is set but no port is eligible, out_valid SHALL be <= 0 and rr_ptr SHALL be unchanged.
REQ-011 Latency SHALL be exactly 1 cycle from the in_valid&&in_ready handshake to out_valid.
REQ-012 out_data SHALL stay stable while out_valid && !out_ready.
REQ-013 Each port SHALL have an 8-bit counter cnt[i], updated as follows:
- +1 on grant to i
- -1 on an accepted done whose tag==i
- unchanged if both happen in the same cycle
REQ-014 A done with tag >= NUM_PORTS SHALL leave all counters unchanged and raise RT_MEMORY_TAG_OOB.
REQ-015 A done with tag==i while cnt[i]==0 SHALL raise RT_MEMORY_DONE_UNDERFLOW, including when port i is granted in the same cycle; the counter SHALL be left unchanged in that case (no net change).
REQ-016 RT_MEMORY_DONE_UNDERFLOW SHALL be added to fabric_common.svh alongside the existing RT_MEMORY_* codes.
REQ-017 If both errors are detected in the same cycle, RT_MEMORY_TAG_OOB SHALL have priority.
REQ-018 The error latch SHALL capture only when error_valid==0, and SHALL hold code and flag until reset; later errors SHALL be ignored.
REQ-019 A port with cnt==MAX_OUTSTANDING SHALL be skipped without stalling other ports.

Reset
REQ-020 On rst_n low, asynchronously, the following SHALL reset:
- out_valid=0, out_data=0
- rr_ptr=0
- all cnt=0
- error_valid=0, error_code=0
REQ-021 A reset asserted mid-transfer SHALL drop the pending output entry; no replay SHALL occur after reset.
REQ-022 in_ready SHALL be 0 for every port while rst_n is low.

Verification
REQ-023 Fairness: NUM_PORTS=2, both sources valid continuously, out_ready=1, dones returned each cycle -> output tags SHALL be 0,1,0,1…
REQ-024 Backpressure: out_ready=0 for 5 cycles with port0 valid, payload 0x10 -> out_data={0,0x10} SHALL hold; in_ready SHALL be 0 after the first accept; 1 request SHALL issue when out_ready rises.
REQ-025 Credit limit: MAX_OUTSTANDING=2, no dones, port1 valid continuously -> exactly 2 grants to port1, then in_ready[1]=0; one done with tag 1 -> exactly one more grant.
REQ-026 Simultaneous grant and done on the same port with cnt=1 -> cnt SHALL remain 1.
REQ-027 Errors:
- done tag 3 with NUM_PORTS=2, TAG_WIDTH=2 -> error_valid=1, error_code=RT_MEMORY_TAG_OOB next cycle
- a subsequent underflow SHALL NOT change error_code
REQ-028 Reset mid-stream: rst_n low while out_valid=1 -> out_valid=0 immediately; after release the first grant SHALL go to port 0.
